fifo_enq_arbiter: RTL and testbench

//  Two-requester, packet-atomic round-robin arbiter sharing the single enqueue port of one FIFO.

---
 rtl/fifo_enq_arbiter.sv | 138 +++++++++++++
 tb/tb_fifo_enq_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_enq_arbiter.sv
// Packet-atomic two-requester round-robin arbiter in front of a single FIFO enqueue port.
// Optional grant revocation on producer stall is enabled by defining ARB_TIMEOUT_EN.
module fifo_enq_arbiter #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    input  logic             req0_last,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    input  logic             req1_last,
    output logic             req1_ready,
    input  logic             fifo_full,
    output logic             fifo_enq,
    output logic [WIDTH-1:0] fifo_din,
    output logic             grant_id,
    output logic             busy,
    output logic             timeout_evt
);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t           state_reg;
    logic             rr_last_reg;
    logic             owner_valid;
    logic             owner_last;
    logic [WIDTH-1:0] owner_data;
    logic             accept;
    logic [1:0]       ready_vec;

    if (TIMEOUT < 1) begin : g_timeout_range
        $error("fifo_enq_arbiter: TIMEOUT must be at least 1");
    end

    // Owner's byte stream selected by state; IDLE presents nothing, so fifo_din is 0.
    always_comb begin
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        owner_data  = '0;
        case (state_reg)
            GRANT0: begin
                owner_valid = req0_valid;
                owner_last  = req0_last;
                owner_data  = req0_data;
            end
            GRANT1: begin
                owner_valid = req1_valid;
                owner_last  = req1_last;
                owner_data  = req1_data;
            end
            default: ;
        endcase
    end

    assign accept   = owner_valid & ~fifo_full;
    assign fifo_enq = accept;
    assign fifo_din = owner_data;
    assign busy     = (state_reg != IDLE);
    assign grant_id = (state_reg == GRANT1);

    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
        localparam state_t GRANT_STATE = (gi == 0) ? GRANT0 : GRANT1;
        assign ready_vec[gi] = accept & (state_reg == GRANT_STATE);
    end

    assign req0_ready = ready_vec[0];
    assign req1_ready = ready_vec[1];

`ifdef ARB_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT + 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);

    logic [STALL_W-1:0] stall_cnt_reg;
    logic               timeout_evt_reg;

    assign timeout_evt = timeout_evt_reg;
`else
    assign timeout_evt = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            rr_last_reg <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            stall_cnt_reg   <= '0;
            timeout_evt_reg <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            timeout_evt_reg <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    // On a tie the requester that did not finish last wins.
                    if (req0_valid && (!req1_valid || rr_last_reg)) begin
                        state_reg <= GRANT0;
                    end else if (req1_valid) begin
                        state_reg <= GRANT1;
                    end
`ifdef ARB_TIMEOUT_EN
                    stall_cnt_reg <= '0;
`endif
                end
                GRANT0, GRANT1: begin
                    if (accept) begin
`ifdef ARB_TIMEOUT_EN
                        stall_cnt_reg <= '0;
`endif
                        if (owner_last) begin
                            state_reg   <= IDLE;
                            rr_last_reg <= (state_reg == GRANT1);
                        end
                    end
`ifdef ARB_TIMEOUT_EN
                    // Only producer silence counts; FIFO-full back-pressure never revokes.
                    else if (!owner_valid) begin
                        if (stall_cnt_reg == STALL_LAST) begin
                            state_reg       <= IDLE;
                            rr_last_reg     <= (state_reg == GRANT1);
                            timeout_evt_reg <= 1'b1;
                            stall_cnt_reg   <= '0;
                        end else begin
                            stall_cnt_reg <= stall_cnt_reg + 1'b1;
                        end
                    end
`endif
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_enq_arbiter.sv
// Bench for fifo_enq_arbiter: directed scenarios plus randomized packet traffic,
// checked cycle by cycle against an owner/round-robin reference model.
module tb_fifo_enq_arbiter;

    localparam int W  = 8;
    localparam int TO = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid, req0_last, req1_valid, req1_last;
    logic [W-1:0] req0_data, req1_data;
    logic         req0_ready, req1_ready;
    logic         fifo_full, fifo_enq, grant_id, busy, timeout_evt;
    logic [W-1:0] fifo_din;

    fifo_enq_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
        .fifo_full(fifo_full), .fifo_enq(fifo_enq), .fifo_din(fifo_din),
        .grant_id(grant_id), .busy(busy), .timeout_evt(timeout_evt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: who owns the port, who finished last, how long the owner has been silent.
    int       m_owner = -1;
    int       m_rr    = 1;
    int       m_stall = 0;
    bit       m_tevt  = 1'b0;
    bit       last_acc0, last_acc1;
    logic [W-1:0] captured[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare one cycle of outputs at the falling edge, then advance the model across the rising edge.
    task automatic step(input string tag);
        logic [1:0]   v;
        logic [1:0]   l;
        logic [W-1:0] ed;
        bit           acc;
        @(negedge clk);
        v   = {req1_valid, req0_valid};
        l   = {req1_last, req0_last};
        acc = (m_owner >= 0) && v[m_owner] && !fifo_full;
        ed  = (m_owner == 0) ? req0_data : (m_owner == 1) ? req1_data : '0;
        check({tag, ".enq"},   32'(fifo_enq),    32'(acc));
        check({tag, ".rdy0"},  32'(req0_ready),  32'(acc && m_owner == 0));
        check({tag, ".rdy1"},  32'(req1_ready),  32'(acc && m_owner == 1));
        check({tag, ".din"},   32'(fifo_din),    32'(ed));
        check({tag, ".busy"},  32'(busy),        32'(m_owner >= 0));
        check({tag, ".gid"},   32'(grant_id),    32'(m_owner == 1));
        check({tag, ".tevt"},  32'(timeout_evt), 32'(m_tevt));
        last_acc0 = acc && m_owner == 0;
        last_acc1 = acc && m_owner == 1;
        if (acc) captured.push_back(ed);
        m_tevt = 1'b0;
        if (reset) begin
            m_owner = -1; m_rr = 1; m_stall = 0;
        end else if (m_owner < 0) begin
            if (v == 2'b11)  m_owner = 1 - m_rr;
            else if (v[0])   m_owner = 0;
            else if (v[1])   m_owner = 1;
            m_stall = 0;
        end else if (acc) begin
            m_stall = 0;
            if (l[m_owner]) begin m_rr = m_owner; m_owner = -1; end
        end
`ifdef ARB_TIMEOUT_EN
        else if (!v[m_owner]) begin
            m_stall++;
            if (m_stall >= TO) begin m_rr = m_owner; m_owner = -1; m_tevt = 1'b1; m_stall = 0; end
        end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic check_stream(input string tag, input logic [W-1:0] exp_q[$]);
        check({tag, ".len"}, 32'(captured.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < captured.size(); i++)
            check($sformatf("%s.byte%0d", tag, i), 32'(captured[i]), 32'(exp_q[i]));
        captured.delete();
    endtask

    logic [W-1:0] pkt0[$], pkt1[$];
    bit           hold0, hold1, gap0, gap1;
    int           guard;

    initial begin
        reset = 1'b1; fifo_full = 1'b0;
        req0_valid = 1'b0; req0_data = '0; req0_last = 1'b0;
        req1_valid = 1'b0; req1_data = '0; req1_last = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        step("reset");
        reset = 1'b0;

        // 1: single three-byte packet from req0
        captured.delete();
        req0_valid = 1'b1; req0_data = 8'h11;
        step("t1.arb");
        step("t1.b0");
        req0_data = 8'h22; step("t1.b1");
        req0_data = 8'h33; req0_last = 1'b1; step("t1.b2");
        req0_valid = 1'b0; req0_last = 1'b0; step("t1.idle");
        check_stream("t1", '{8'h11, 8'h22, 8'h33});

        // 2: tie after reset goes to req0, then req1
        reset = 1'b1; step("t2.rst"); reset = 1'b0;
        req0_valid = 1'b1; req0_data = 8'hA1; req0_last = 1'b0;
        req1_valid = 1'b1; req1_data = 8'hB1; req1_last = 1'b1;
        step("t2.arb");
        step("t2.a1");
        req0_data = 8'hA2; req0_last = 1'b1; step("t2.a2");
        req0_valid = 1'b0; req0_last = 1'b0; step("t2.arb1");
        step("t2.b1");
        req1_valid = 1'b0; req1_last = 1'b0; step("t2.idle");
        check_stream("t2", '{8'hA1, 8'hA2, 8'hB1});

        // 3: FIFO full stalls req1 mid-packet
        req1_valid = 1'b1; req1_data = 8'h51;
        step("t3.arb");
        step("t3.b0");
        req1_data = 8'h5A; req1_last = 1'b1; fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) step($sformatf("t3.full%0d", i));
        fifo_full = 1'b0; step("t3.b1");
        req1_valid = 1'b0; req1_last = 1'b0; step("t3.idle");
        check_stream("t3", '{8'h51, 8'h5A});

        // 4: req1 waits with 0xFF while req0 owns the port
        req0_valid = 1'b1; req0_data = 8'h01;
        step("t4.arb");
        req1_valid = 1'b1; req1_data = 8'hFF; req1_last = 1'b1;
        step("t4.a0");
        req0_data = 8'h02; step("t4.a1");
        req0_data = 8'h03; req0_last = 1'b1; step("t4.a2");
        req0_valid = 1'b0; req0_last = 1'b0; step("t4.arb1");
        step("t4.ff");
        req1_valid = 1'b0; req1_last = 1'b0; step("t4.idle");
        check_stream("t4", '{8'h01, 8'h02, 8'h03, 8'hFF});

        // 5: reset mid-packet, then re-arbitration of a tie
        req0_valid = 1'b1; req0_data = 8'hC1;
        step("t5.arb");
        step("t5.c1");
        reset = 1'b1; req0_data = 8'hC2; step("t5.rst");
        reset = 1'b0;
        req1_valid = 1'b1; req1_data = 8'hD1; req1_last = 1'b1;
        step("t5.rearb");
        check("t5.owner0", 32'(busy), 32'd1);
        req0_data = 8'hC3; req0_last = 1'b1; step("t5.c3");
        req0_valid = 1'b0; req0_last = 1'b0; step("t5.arb1");
        step("t5.d1");
        req1_valid = 1'b0; req1_last = 1'b0; step("t5.idle");
        check_stream("t5", '{8'hC1, 8'hC2, 8'hC3, 8'hD1});

        // 6: producer goes silent mid-packet
        req0_valid = 1'b1; req0_data = 8'hE1;
        step("t6.arb");
        step("t6.e1");
        req0_valid = 1'b0;
        for (int i = 0; i < 6; i++) step($sformatf("t6.stall%0d", i));
`ifdef ARB_TIMEOUT_EN
        check("t6.busy_end", 32'(busy), 32'd0);
`else
        check("t6.busy_end", 32'(busy), 32'd1);
`endif
        reset = 1'b1; step("t6.rst"); reset = 1'b0;
        captured.delete();

        // Random packet traffic with back-pressure and single-cycle producer gaps
        hold0 = 1'b0; hold1 = 1'b0; gap0 = 1'b0; gap1 = 1'b0;
        guard = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (cyc < 600) begin
                if (pkt0.size() == 0 && $urandom_range(0, 3) == 0)
                    for (int k = 0, n = $urandom_range(1, 5); k < n; k++) pkt0.push_back(W'($urandom));
                if (pkt1.size() == 0 && $urandom_range(0, 3) == 0)
                    for (int k = 0, n = $urandom_range(1, 5); k < n; k++) pkt1.push_back(W'($urandom));
            end else if (pkt0.size() == 0 && pkt1.size() == 0 && !busy) begin
                break;
            end
            gap0 = !hold0 && !gap0 && $urandom_range(0, 4) == 0;
            gap1 = !hold1 && !gap1 && $urandom_range(0, 4) == 0;
            req0_valid = pkt0.size() > 0 && !gap0;
            req1_valid = pkt1.size() > 0 && !gap1;
            req0_data  = req0_valid ? pkt0[0] : W'($urandom);
            req1_data  = req1_valid ? pkt1[0] : W'($urandom);
            req0_last  = pkt0.size() == 1;
            req1_last  = pkt1.size() == 1;
            fifo_full  = $urandom_range(0, 3) == 0;
            step("rnd");
            if (last_acc0) void'(pkt0.pop_front());
            if (last_acc1) void'(pkt1.pop_front());
            hold0 = req0_valid && !last_acc0;
            hold1 = req1_valid && !last_acc1;
            guard = cyc;
        end
        check("rnd.drained", 32'(pkt0.size() + pkt1.size()), 32'd0);
        check("rnd.in_budget", 32'(guard < 1999), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
